// File: rtl/uart_alu_ctrl.sv
// Sequences UART RX bytes (A, B, opcode) into the ALU and hands the result to UART TX.
// Optional inter-byte timeout: define UART_CTRL_TIMEOUT_EN.
module uart_alu_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int OP_WIDTH      = 6,
  parameter int TIMEOUT_TICKS = 2560
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_tick,
  input  logic                  i_rx_done,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic                  i_tx_done,
  output logic [DATA_WIDTH-1:0] o_alu_a,
  output logic [DATA_WIDTH-1:0] o_alu_b,
  output logic [OP_WIDTH-1:0]   o_alu_op,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_error
);

  typedef enum logic [5:0] {
    S_WAIT_A  = 6'b000001,
    S_WAIT_B  = 6'b000010,
    S_WAIT_OP = 6'b000100,
    S_COMPUTE = 6'b001000,
    S_SEND    = 6'b010000,
    S_WAIT_TX = 6'b100000
  } state_t;

  state_t state;
  logic   timeout;
  logic   collecting;

  assign collecting = (state == S_WAIT_B) || (state == S_WAIT_OP);
  assign o_tx_start = (state == S_SEND);
  assign o_busy     = (state == S_COMPUTE) || (state == S_SEND) || (state == S_WAIT_TX);

`ifdef UART_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_TICKS);

  logic [CW-1:0] tick_cnt;

  assign timeout = collecting && (tick_cnt == TO_MAX);

  // Counter only runs between bytes of a partially received transaction.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      tick_cnt <= '0;
      o_error  <= 1'b0;
    end else begin
      o_error <= timeout;
      if (timeout || i_rx_done || (state == S_WAIT_A)) begin
        tick_cnt <= '0;
      end else if (i_tick && collecting && (tick_cnt != TO_MAX)) begin
        tick_cnt <= tick_cnt + CW'(1);
      end
    end
  end
`else
  logic unused_tick;

  assign unused_tick = i_tick ^ collecting;
  assign timeout     = 1'b0;
  assign o_error     = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= S_WAIT_A;
      o_alu_a   <= '0;
      o_alu_b   <= '0;
      o_alu_op  <= '0;
      o_tx_data <= '0;
      o_overrun <= 1'b0;
    end else begin
      // A byte arriving while a result is in flight has nowhere to go.
      if (i_rx_done && o_busy) begin
        o_overrun <= 1'b1;
      end
      if (timeout) begin
        state <= S_WAIT_A;
      end else begin
        case (state)
          S_WAIT_A: begin
            if (i_rx_done) begin
              o_alu_a <= i_rx_data;
              state   <= S_WAIT_B;
            end
          end
          S_WAIT_B: begin
            if (i_rx_done) begin
              o_alu_b <= i_rx_data;
              state   <= S_WAIT_OP;
            end
          end
          S_WAIT_OP: begin
            if (i_rx_done) begin
              o_alu_op <= i_rx_data[OP_WIDTH-1:0];
              state    <= S_COMPUTE;
            end
          end
          S_COMPUTE: begin
            o_tx_data <= i_alu_result;
            state     <= S_SEND;
          end
          S_SEND: begin
            state <= S_WAIT_TX;
          end
          S_WAIT_TX: begin
            if (i_tx_done) begin
              state <= S_WAIT_A;
            end
          end
          default: begin
            state <= S_WAIT_A;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: directed transactions plus random traffic against a
// transaction-level model with an expected-result queue.
module tb_uart_alu_ctrl;

`ifdef UART_CTRL_TIMEOUT_EN
  localparam int TT = 8;
`else
  localparam int TT = 2560;
`endif

  logic       i_clock = 1'b0;
  logic       i_reset, i_tick, i_rx_done, i_tx_done;
  logic [7:0] i_rx_data, i_alu_result;
  logic [7:0] o_alu_a, o_alu_b, o_tx_data;
  logic [5:0] o_alu_op;
  logic       o_tx_start, o_busy, o_overrun, o_error;

  uart_alu_ctrl #(.DATA_WIDTH(8), .OP_WIDTH(6), .TIMEOUT_TICKS(TT)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_tick(i_tick),
    .i_rx_done(i_rx_done), .i_rx_data(i_rx_data), .i_alu_result(i_alu_result),
    .i_tx_done(i_tx_done), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .o_tx_start(o_tx_start), .o_tx_data(o_tx_data), .o_busy(o_busy),
    .o_overrun(o_overrun), .o_error(o_error)
  );

  // clock / reset
  always #5 i_clock = ~i_clock;

  // ALU stub: 0x20 add, 0x22 subtract, anything else xor.
  function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    case (op)
      6'h20:   alu_ref = a + b;
      6'h22:   alu_ref = a - b;
      default: alu_ref = a ^ b;
    endcase
  endfunction

  assign i_alu_result = alu_ref(o_alu_a, o_alu_b, o_alu_op);

  // scoreboard and model
  int         vectors = 0;
  int         miscompares = 0;
  int         n_starts = 0;
  logic [7:0] exp_q[$];
  logic [7:0] m_a, m_b, m_txd;
  logic [5:0] m_op;
  int         m_cnt, m_since_op, m_ticks;
  logic       m_ovr, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // m_cnt: bytes held of the current transaction; m_since_op: cycles since the
  // opcode byte was taken (0 = not in flight, 3 = waiting for TX to finish).
  task automatic model_step(input logic rst, input logic rx, input logic [7:0] d,
                            input logic txd, input logic tk);
    logic tout, pre_collect;
    if (rst) begin
      m_a = 0; m_b = 0; m_op = 0; m_txd = 0; m_cnt = 0; m_since_op = 0;
      m_ticks = 0; m_ovr = 0; m_err = 0;
      exp_q.delete();
    end else begin
      pre_collect = (m_since_op == 0) && (m_cnt > 0);
      tout = 1'b0;
`ifdef UART_CTRL_TIMEOUT_EN
      tout = pre_collect && (m_ticks == TT);
`endif
      m_err = tout;
      if (rx && m_since_op != 0) m_ovr = 1'b1;
      if (tout) begin
        m_cnt = 0;
      end else if (m_since_op == 1) begin
        m_txd = alu_ref(m_a, m_b, m_op);
        m_since_op = 2;
      end else if (m_since_op == 2) begin
        m_since_op = 3;
      end else if (m_since_op == 3) begin
        if (txd) begin
          m_since_op = 0;
          m_cnt = 0;
        end
      end else if (rx) begin
        if (m_cnt == 0) m_a = d;
        else if (m_cnt == 1) m_b = d;
        else begin
          m_op = d[5:0];
          m_since_op = 1;
          exp_q.push_back(alu_ref(m_a, m_b, m_op));
        end
        m_cnt = (m_cnt == 2) ? 0 : m_cnt + 1;
      end
      if (tout || rx || !pre_collect) m_ticks = 0;
      else if (tk && m_ticks < TT) m_ticks++;
    end
  endtask

  task automatic compare_all();
    logic [7:0] e;
    chk("alu_a", o_alu_a, m_a);
    chk("alu_b", o_alu_b, m_b);
    chk("alu_op", o_alu_op, m_op);
    chk("tx_data", o_tx_data, m_txd);
    chk("tx_start", o_tx_start, (m_since_op == 2));
    chk("busy", o_busy, (m_since_op != 0));
    chk("overrun", o_overrun, m_ovr);
    chk("error", o_error, m_err);
    if (o_tx_start) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_start", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", o_tx_data, e);
      end
    end
  endtask

  // driver tasks
  task automatic step(input logic rst, input logic rx, input logic [7:0] d,
                      input logic txd, input logic tk);
    i_reset = rst; i_rx_done = rx; i_rx_data = d; i_tx_done = txd; i_tick = tk;
    model_step(rst, rx, d, txd, tk);
    @(posedge i_clock);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    send(a); send(b); send(op);
    idle(); idle();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    int s;
    logic rx, txd;
    i_reset = 1'b1; i_rx_done = 1'b0; i_rx_data = '0; i_tx_done = 1'b0; i_tick = 1'b0;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_busy", o_busy, 0);
    chk("rst_tx_data", o_tx_data, 0);

    // single add transaction with exact start latency
    send(8'h05); send(8'h03); send(8'h20);
    chk("t1_a", o_alu_a, 8'h05);
    chk("t1_b", o_alu_b, 8'h03);
    chk("t1_op", o_alu_op, 6'h20);
    chk("t1_no_start_yet", o_tx_start, 0);
    idle();
    chk("t1_start", o_tx_start, 1);
    chk("t1_tx_data", o_tx_data, 8'h08);
    idle();
    chk("t1_single_pulse", o_tx_start, 0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t1_idle", o_busy, 0);

    // back-to-back
    s = n_starts;
    txn(8'hFF, 8'h01, 8'h20);
    chk("t2_first", o_tx_data, 8'h00);
    txn(8'h10, 8'h04, 8'h22);
    chk("t2_second", o_tx_data, 8'h0C);
    chk("t2_two_starts", n_starts - s, 2);

    // reset in WAIT_OP
    send(8'h11); send(8'h22);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("t4_a0", o_alu_a, 0);
    chk("t4_b0", o_alu_b, 0);
    chk("t4_busy0", o_busy, 0);
    txn(8'h07, 8'h02, 8'h20);
    chk("t4_result", o_tx_data, 8'h09);

    // simultaneous rx and tx done in WAIT_TX
    send(8'h01); send(8'h02); send(8'h20); idle(); idle();
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b0);
    chk("t6_idle", o_busy, 0);
    chk("t6_overrun", o_overrun, 1);
    idle();
    chk("t6_a_kept", o_alu_a, 8'h01);
    txn(8'h09, 8'h01, 8'h22);
    chk("t6_next", o_tx_data, 8'h08);

    // overrun during WAIT_TX
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    send(8'h01); send(8'h02); send(8'h20); idle(); idle();
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("t3_overrun", o_overrun, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    txn(8'h33, 8'h44, 8'h22);
    chk("t3_a", o_alu_a, 8'h33);
    chk("t3_sticky", o_overrun, 1);
    chk("t3_result", o_tx_data, 8'hEF);

`ifdef UART_CTRL_TIMEOUT_EN
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    send(8'h05);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    idle();
    chk("t5_error", o_error, 1);
    idle();
    chk("t5_error_pulse", o_error, 0);
    txn(8'h01, 8'h02, 8'h20);
    chk("t5_new_txn", o_tx_data, 8'h03);
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (m_since_op == 0) rx = ($urandom_range(0, 3) == 0);
      else rx = ($urandom_range(0, 9) == 0);
      if (m_since_op == 3) txd = ($urandom_range(0, 4) == 0);
      else txd = ($urandom_range(0, 19) == 0);
      step(($urandom_range(0, 299) == 0), rx, 8'($urandom_range(0, 255)), txd,
           ($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
